multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu_if.sv | 27 ++
 rtl/multicycle_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu: operand request channel and
// registered result channel, each with its own valid/ready pair.
interface multicycle_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             div_zero;
  logic             bad_op;

  modport master (
    output in_valid, in1, in2, alu_op, out_ready,
    input  in_ready, out_valid, alu_result, zero, div_zero, bad_op
  );

  modport slave (
    input  in_valid, in1, in2, alu_op, out_ready,
    output in_ready, out_valid, alu_result, zero, div_zero, bad_op
  );
endinterface

// File: rtl/multicycle_alu.sv
// ALU with single-cycle logic/arith ops and iterative shift-add multiply and
// restoring divide; one operation in flight, result held until consumed.
module multicycle_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  multicycle_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0011;
  localparam logic [3:0] OP_SHR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;

  logic [3:0]       op_r;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             div_zero_r;
  logic             bad_op_r;

  logic             accept;
  logic             is_div;
  logic             is_multi;
  logic             go_busy;
  logic             last_iter;
  logic             big_shift;

  logic [WIDTH-1:0] single_res;
  logic             single_dz;
  logic             single_bad;

  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] iter_res;

  assign accept    = bus.in_valid && (state == IDLE);
  assign is_div    = (bus.alu_op == OP_DIVU) || (bus.alu_op == OP_REMU);
  assign is_multi  = is_div || (bus.alu_op == OP_MUL);
  // Division by zero has a defined answer, so it bypasses the iteration.
  assign go_busy   = is_multi && !(is_div && (bus.in2 == '0));
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign big_shift = (bus.in2 >= WIDTH'(WIDTH));

  always_comb begin
    single_res = '0;
    single_dz  = 1'b0;
    single_bad = 1'b0;
    case (bus.alu_op)
      OP_ADD:  single_res = bus.in1 + bus.in2;
      OP_SUB:  single_res = bus.in1 - bus.in2;
      OP_NOT:  single_res = ~bus.in1;
      OP_SHL:  single_res = big_shift ? '0 : (bus.in1 << bus.in2[SHW-1:0]);
      OP_SHR:  single_res = big_shift ? '0 : (bus.in1 >> bus.in2[SHW-1:0]);
      OP_AND:  single_res = bus.in1 & bus.in2;
      OP_OR:   single_res = bus.in1 | bus.in2;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
      OP_XOR:  single_res = bus.in1 ^ bus.in2;
      OP_SRA:  single_res = big_shift ? {WIDTH{bus.in1[WIDTH-1]}}
                                      : $unsigned($signed(bus.in1) >>> bus.in2[SHW-1:0]);
      OP_MUL:  single_res = '0;
      OP_DIVU: begin
        single_res = '1;
        single_dz  = 1'b1;
      end
      OP_REMU: begin
        single_res = bus.in1;
        single_dz  = 1'b1;
      end
      default: single_bad = 1'b1;
    endcase
  end

  // reg_a doubles as multiplicand (MUL) or dividend-becoming-quotient (DIV);
  // acc is the running product or partial remainder.
  always_comb begin
    mul_sum   = acc + (reg_b[0] ? reg_a : '0);
    rem_shift = {acc, reg_a[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, reg_b});
    rem_next  = rem_ge ? WIDTH'(rem_shift - {1'b0, reg_b}) : rem_shift[WIDTH-1:0];
    quo_next  = {reg_a[WIDTH-2:0], rem_ge};
    case (op_r)
      OP_MUL:  iter_res = mul_sum;
      OP_DIVU: iter_res = quo_next;
      default: iter_res = rem_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = go_busy ? BUSY : DONE;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r       <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      acc        <= '0;
      cnt        <= '0;
      result_r   <= '0;
      zero_r     <= 1'b1;
      div_zero_r <= 1'b0;
      bad_op_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r  <= bus.alu_op;
            reg_a <= bus.in1;
            reg_b <= bus.in2;
            acc   <= '0;
            cnt   <= '0;
            if (!go_busy) begin
              result_r   <= single_res;
              zero_r     <= (single_res == '0);
              div_zero_r <= single_dz;
              bad_op_r   <= single_bad;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (op_r == OP_MUL) begin
            acc   <= mul_sum;
            reg_a <= reg_a << 1;
            reg_b <= reg_b >> 1;
          end else begin
            acc   <= rem_next;
            reg_a <= quo_next;
          end
          if (last_iter) begin
            result_r   <= iter_res;
            zero_r     <= (iter_res == '0);
            div_zero_r <= 1'b0;
            bad_op_r   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.alu_result = result_r;
  assign bus.zero       = zero_r;
  assign bus.div_zero   = div_zero_r;
  assign bus.bad_op     = bad_op_r;

endmodule
